// File: rtl/fg_strobe_emulator.sv
// Frame-grabber strobe emulator: emits a programmable train of fg strobes on a
// start edge and measures the rise-to-trigger latency of the returned trigger.
module fg_strobe_emulator #(
  parameter int CNT_W = 32,
  parameter int IDX_W = 16
) (
  input  logic             clock,
  input  logic             reset_signal,
  input  logic             start_signal,
  input  logic             abort,
  input  logic [CNT_W-1:0] fg_period,
  input  logic [CNT_W-1:0] fg_pulse_len,
  input  logic [IDX_W-1:0] fg_count,
  input  logic [CNT_W-1:0] resp_timeout,
  input  logic             trigger_in,
  output logic             fg_signal,
  output logic             busy,
  output logic [IDX_W-1:0] frame_idx,
  output logic [CNT_W-1:0] latency,
  output logic             latency_valid,
  output logic             timeout_pulse,
  output logic             cfg_error,
  output logic [IDX_W-1:0] spurious_cnt,
  output logic [7:0]       scenario_state
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    STROBE_HIGH = 2'd1,
    STROBE_LOW  = 2'd2
  } state_t;

  state_t state, state_next;

  logic start_s1, start_s2;
  logic trig_s1, trig_s2;
  logic start_edge, trig_edge;

  logic [CNT_W-1:0] period_cfg;
  logic [CNT_W-1:0] pulse_cfg;
  logic [IDX_W-1:0] count_cfg;
  logic [CNT_W-1:0] timeout_cfg;

  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] resp_cnt;
  logic             awaiting;

  logic cfg_ok, last_high, last_low, last_frame;
  logic rise, launch, reject, train_end, timeout_hit;

  // Two-flop synchronizers for the asynchronous start and trigger inputs.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      trig_s1  <= 1'b0;
      trig_s2  <= 1'b0;
    end else begin
      start_s1 <= start_signal;
      start_s2 <= start_s1;
      trig_s1  <= trigger_in;
      trig_s2  <= trig_s1;
    end
  end

  assign start_edge = start_s1 & ~start_s2;
  assign trig_edge  = trig_s1 & ~trig_s2;

  assign cfg_ok     = (fg_pulse_len != '0) && (fg_period > fg_pulse_len);
  assign last_high  = (phase == pulse_cfg - CNT_W'(1));
  assign last_low   = (phase == period_cfg - CNT_W'(1));
  assign last_frame = (count_cfg != '0) && (frame_idx == count_cfg - IDX_W'(1));

  always_comb begin
    state_next = state;
    rise       = 1'b0;
    launch     = 1'b0;
    reject     = 1'b0;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            if (cfg_ok) begin
              state_next = STROBE_HIGH;
              rise       = 1'b1;
              launch     = 1'b1;
            end else begin
              reject = 1'b1;
            end
          end
        end
        STROBE_HIGH: begin
          if (last_high) state_next = STROBE_LOW;
        end
        STROBE_LOW: begin
          if (last_low) begin
            if (last_frame) begin
              state_next = IDLE;
            end else begin
              state_next = STROBE_HIGH;
              rise       = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Leaving for IDLE at the end of a train closes the window without a timeout.
  assign train_end   = (state != IDLE) && (state_next == IDLE);
  assign timeout_hit = awaiting && (timeout_cfg != '0) && (resp_cnt == timeout_cfg) && !train_end;

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      state     <= IDLE;
      fg_signal <= 1'b0;
      busy      <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state     <= state_next;
      fg_signal <= (state_next == STROBE_HIGH);
      busy      <= (state_next != IDLE);
      cfg_error <= reject;
    end
  end

  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      period_cfg  <= '0;
      pulse_cfg   <= '0;
      count_cfg   <= '0;
      timeout_cfg <= '0;
    end else if (state == IDLE && start_edge) begin
      period_cfg  <= fg_period;
      pulse_cfg   <= fg_pulse_len;
      count_cfg   <= fg_count;
      timeout_cfg <= resp_timeout;
    end
  end

  // Phase restarts at every rise; frame_idx wraps naturally in continuous mode.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      phase     <= '0;
      frame_idx <= '0;
    end else begin
      if (rise) begin
        phase <= '0;
      end else if (state != IDLE) begin
        phase <= phase + CNT_W'(1);
      end
      if (launch) begin
        frame_idx <= '0;
      end else if (rise) begin
        frame_idx <= frame_idx + IDX_W'(1);
      end
    end
  end

  // A trigger edge coinciding with a new rise is settled against the old
  // window first; the new window assignment below then takes over.
  always_ff @(posedge clock or posedge reset_signal) begin
    if (reset_signal) begin
      resp_cnt      <= '0;
      awaiting      <= 1'b0;
      latency       <= '0;
      latency_valid <= 1'b0;
      timeout_pulse <= 1'b0;
      spurious_cnt  <= '0;
    end else begin
      latency_valid <= 1'b0;
      timeout_pulse <= 1'b0;
      if (abort) begin
        awaiting <= 1'b0;
      end else begin
        if (awaiting) resp_cnt <= resp_cnt + CNT_W'(1);
        if (state != IDLE && trig_edge) begin
          if (awaiting) begin
            latency       <= resp_cnt;
            latency_valid <= 1'b1;
            awaiting      <= 1'b0;
          end else if (spurious_cnt != '1) begin
            spurious_cnt <= spurious_cnt + IDX_W'(1);
          end
        end else if (timeout_hit) begin
          timeout_pulse <= 1'b1;
          awaiting      <= 1'b0;
        end
        if (train_end) awaiting <= 1'b0;
        if (rise) begin
          resp_cnt <= '0;
          awaiting <= 1'b1;
        end
        if (launch) spurious_cnt <= '0;
      end
    end
  end

  assign scenario_state = {6'b0, state};

endmodule

// File: tb/tb_fg_strobe_emulator.sv
// Directed bench for fg_strobe_emulator: a cycle table for a short train plus
// hand-built sequences for loopback, timeouts, config rejection, abort and reset.
module tb_fg_strobe_emulator;
  localparam int CNT_W = 32;
  localparam int IDX_W = 16;

  logic             clock = 1'b0;
  logic             reset_signal;
  logic             start_signal;
  logic             abort;
  logic [CNT_W-1:0] fg_period;
  logic [CNT_W-1:0] fg_pulse_len;
  logic [IDX_W-1:0] fg_count;
  logic [CNT_W-1:0] resp_timeout;
  logic             trigger_in;
  logic             fg_signal;
  logic             busy;
  logic [IDX_W-1:0] frame_idx;
  logic [CNT_W-1:0] latency;
  logic             latency_valid;
  logic             timeout_pulse;
  logic             cfg_error;
  logic [IDX_W-1:0] spurious_cnt;
  logic [7:0]       scenario_state;

  logic trig_drv;
  logic loop_en;
  assign trigger_in = loop_en ? fg_signal : trig_drv;

  always #5 clock = ~clock;

  fg_strobe_emulator #(.CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clock          (clock),
    .reset_signal   (reset_signal),
    .start_signal   (start_signal),
    .abort          (abort),
    .fg_period      (fg_period),
    .fg_pulse_len   (fg_pulse_len),
    .fg_count       (fg_count),
    .resp_timeout   (resp_timeout),
    .trigger_in     (trigger_in),
    .fg_signal      (fg_signal),
    .busy           (busy),
    .frame_idx      (frame_idx),
    .latency        (latency),
    .latency_valid  (latency_valid),
    .timeout_pulse  (timeout_pulse),
    .cfg_error      (cfg_error),
    .spurious_cnt   (spurious_cnt),
    .scenario_state (scenario_state)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s: %0d ok", name, act);
    end
  endtask

  typedef struct {
    logic             start;
    logic             trig;
    logic             fg;
    logic             bsy;
    logic [IDX_W-1:0] frame;
    logic             lv;
    logic [CNT_W-1:0] lat;
    logic [IDX_W-1:0] spur;
    logic [7:0]       st;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit t, input bit f, input bit b, input int fr,
                              input bit lv, input int lat, input int sp, input int st);
    vec_t v;
    v.start = s;
    v.trig  = t;
    v.fg    = f;
    v.bsy   = b;
    v.frame = IDX_W'(fr);
    v.lv    = lv;
    v.lat   = CNT_W'(lat);
    v.spur  = IDX_W'(sp);
    v.st    = 8'(st);
    return v;
  endfunction

  // Train monitor results
  int               rise_cyc [16];
  int               high_len [16];
  int               lat_v    [16];
  int               to_off   [16];
  logic [IDX_W-1:0] frame_at_rise [16];
  int               n_rise, n_lv, n_to, n_cfg, fall_cyc;
  bit               got_busy, ever_fg, state_seen;
  logic             fall_fg;
  logic [IDX_W-1:0] fall_frame;
  logic [7:0]       fall_state;

  // Starts a train and watches it; trigger pulses are driven at bench phases pa/pb.
  task automatic run_train(input int pa, input int pb, input int max_cyc, input int abort_at);
    int  phase;
    bit  prev_fg;
    n_rise = 0; n_lv = 0; n_to = 0; n_cfg = 0; fall_cyc = -1;
    got_busy = 0; ever_fg = 0; state_seen = 0; prev_fg = 0; phase = 100000;
    fall_fg = 1'bx; fall_frame = 'x; fall_state = 'x;
    @(negedge clock);
    start_signal = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clock);
      if (cyc == 3) start_signal = 1'b0;
      abort = 1'b0;
      if (busy) got_busy = 1;
      if (cfg_error) n_cfg++;
      if (fg_signal) ever_fg = 1;
      if (scenario_state != 8'd0) state_seen = 1;
      if (fg_signal && !prev_fg) begin
        if (n_rise < 16) begin
          rise_cyc[n_rise]      = cyc;
          frame_at_rise[n_rise] = frame_idx;
          high_len[n_rise]      = 0;
        end
        n_rise++;
        phase = 0;
        if (n_rise == abort_at) abort = 1'b1;
      end else begin
        phase++;
      end
      if (fg_signal && n_rise > 0 && n_rise <= 16) high_len[n_rise-1]++;
      if (latency_valid) begin
        if (n_lv < 16) lat_v[n_lv] = int'(latency);
        n_lv++;
      end
      if (timeout_pulse) begin
        if (n_to < 16 && n_rise > 0) to_off[n_to] = cyc - rise_cyc[(n_rise-1) % 16];
        n_to++;
      end
      trig_drv = (phase == pa) || (phase == pb);
      prev_fg  = fg_signal;
      if (got_busy && !busy) begin
        fall_cyc   = cyc;
        fall_fg    = fg_signal;
        fall_frame = frame_idx;
        fall_state = scenario_state;
        break;
      end
    end
    trig_drv     = 1'b0;
    start_signal = 1'b0;
    abort        = 1'b0;
  endtask

  task automatic set_cfg(input int per, input int pl, input int cnt, input int tmo);
    fg_period    = CNT_W'(per);
    fg_pulse_len = CNT_W'(pl);
    fg_count     = IDX_W'(cnt);
    resp_timeout = CNT_W'(tmo);
  endtask

  vec_t vecs [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_signal = 1'b1;
    start_signal = 1'b0;
    abort        = 1'b0;
    trig_drv     = 1'b0;
    loop_en      = 1'b0;
    set_cfg(4, 2, 2, 0);

    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 1, 1, 1, 0, 0, 0, 0, 1);
    vecs[3]  = mk(1, 0, 1, 1, 0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 0, 1, 0, 1, 1, 0, 2);
    vecs[5]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 2);
    vecs[6]  = mk(1, 0, 1, 1, 1, 0, 1, 1, 1);
    vecs[7]  = mk(1, 1, 1, 1, 1, 0, 1, 1, 1);
    vecs[8]  = mk(1, 0, 0, 1, 1, 0, 1, 1, 2);
    vecs[9]  = mk(1, 0, 0, 1, 1, 1, 2, 1, 2);
    vecs[10] = mk(1, 1, 0, 0, 1, 0, 2, 1, 0);
    vecs[11] = mk(1, 0, 0, 0, 1, 0, 2, 1, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 2, 1, 0);

    repeat (3) @(negedge clock);
    check("reset_outputs",
          {fg_signal, busy, frame_idx, latency, latency_valid, timeout_pulse, cfg_error},
          64'd0);
    check("reset_spur_state", {spurious_cnt, scenario_state}, 64'd0);
    reset_signal = 1'b0;
    repeat (2) @(negedge clock);

    // Cycle table: period 4, pulse 2, count 2; trigger and a busy-time start edge.
    for (int k = 0; k < 13; k++) begin
      @(negedge clock);
      n_vec++;
      if (fg_signal !== vecs[k].fg || busy !== vecs[k].bsy || frame_idx !== vecs[k].frame ||
          latency_valid !== vecs[k].lv || latency !== vecs[k].lat ||
          spurious_cnt !== vecs[k].spur || scenario_state !== vecs[k].st ||
          cfg_error !== 1'b0 || timeout_pulse !== 1'b0) begin
        n_miss++;
        $display("FAIL vec%0d: got fg=%b busy=%b fr=%0d lv=%b lat=%0d sp=%0d st=%0d ce=%b to=%b, expected fg=%b busy=%b fr=%0d lv=%b lat=%0d sp=%0d st=%0d ce=0 to=0",
                 k, fg_signal, busy, frame_idx, latency_valid, latency, spurious_cnt, scenario_state,
                 cfg_error, timeout_pulse, vecs[k].fg, vecs[k].bsy, vecs[k].frame, vecs[k].lv,
                 vecs[k].lat, vecs[k].spur, vecs[k].st);
      end else begin
        $display("vec%0d ok", k);
      end
      start_signal = vecs[k].start;
      trig_drv     = vecs[k].trig;
    end
    start_signal = 1'b0;
    trig_drv     = 1'b0;
    repeat (3) @(negedge clock);

    // Loopback: trigger tied to fg, latency must be 1 for every frame.
    loop_en = 1'b1;
    set_cfg(10, 3, 4, 0);
    run_train(-1, -1, 80, 0);
    loop_en = 1'b0;
    check("lb_rises", n_rise, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lb_high_len%0d", k), high_len[k], 3);
      check($sformatf("lb_frame%0d", k), frame_at_rise[k], k);
      check($sformatf("lb_latency%0d", k), lat_v[k], 1);
      if (k > 0) check($sformatf("lb_spacing%0d", k), rise_cyc[k] - rise_cyc[k-1], 10);
    end
    check("lb_lv_count", n_lv, 4);
    check("lb_busy_fall", fall_cyc - rise_cyc[0], 40);

    // Two trigger edges per frame: first measured at phase 2, second is spurious.
    set_cfg(10, 3, 3, 0);
    run_train(1, 5, 60, 0);
    check("dbl_lv_count", n_lv, 3);
    for (int k = 0; k < 3; k++) check($sformatf("dbl_latency%0d", k), lat_v[k], 2);
    check("dbl_spurious", spurious_cnt, 3);

    // Timeouts: no trigger until after the timeout, then a late (spurious) edge.
    set_cfg(60, 3, 4, 50);
    run_train(55, -1, 300, 0);
    check("to_count", n_to, 4);
    check("to_lv_count", n_lv, 0);
    for (int k = 0; k < 4; k++) check($sformatf("to_offset%0d", k), to_off[k], 51);
    check("to_spurious", spurious_cnt, 4);

    // Invalid configurations are rejected with one cfg_error pulse.
    set_cfg(10, 0, 1, 0);
    run_train(-1, -1, 12, 0);
    check("cfg0_error", n_cfg, 1);
    check("cfg0_no_fg", {ever_fg, got_busy, state_seen}, 0);
    set_cfg(3, 3, 1, 0);
    run_train(-1, -1, 12, 0);
    check("cfg1_error", n_cfg, 1);
    check("cfg1_no_fg", {ever_fg, got_busy, state_seen}, 0);

    // Continuous train aborted on the 7th rise, then restarted from frame 0.
    set_cfg(8, 2, 0, 0);
    run_train(-1, -1, 100, 7);
    check("abort_rises", n_rise, 7);
    check("abort_fall_cycle", fall_cyc - rise_cyc[6], 1);
    check("abort_fg", fall_fg, 0);
    check("abort_state", fall_state, 0);
    check("abort_frame", fall_frame, 6);
    run_train(-1, -1, 40, 1);
    check("restart_frame", frame_at_rise[0], 0);
    check("restart_abort_frame", fall_frame, 0);

    // Asynchronous reset in the middle of a high phase.
    set_cfg(10, 3, 2, 0);
    @(negedge clock);
    start_signal = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 3) start_signal = 1'b0;
      if (fg_signal) break;
    end
    start_signal = 1'b0;
    check("rst_reached_high", fg_signal, 1);
    #1 reset_signal = 1'b1;
    #1;
    check("rst_async_fg_busy", {fg_signal, busy}, 0);
    check("rst_async_outputs",
          {frame_idx, latency, latency_valid, timeout_pulse, cfg_error, scenario_state}, 64'd0);
    @(negedge clock);
    reset_signal = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
